// File: rtl/instruction_loader_pkg.sv
// Shared types and helpers for the instruction loader: FSM state encoding,
// word size and byte-address computation.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    DATA,
    WRITE,
    CHK,
    VERIFY,
    DONE,
    ERROR
  } loader_state_t;

  localparam int unsigned BYTES_PER_WORD = 4;

  // Word index to byte address; callers truncate to the memory address width.
  function automatic logic [31:0] word_addr(input logic [31:0] idx);
    return idx << 2;
  endfunction

endpackage

// File: rtl/instruction_loader_byte_packer.sv
// Little-endian byte-to-word shifter shared by header, data and checksum
// collection; the first accepted byte lands in bits [7:0].
module byte_packer
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic [31:0] word_next_o,
  output logic        complete_o,
  output logic        word_valid_o
);

  logic [1:0]  cnt_q;
  logic [31:0] word_q;
  logic        valid_q;

  // word_next_o/complete_o let the FSM act on the edge that takes the last byte.
  assign word_next_o  = {byte_i, word_q[31:8]};
  assign complete_o   = byte_valid_i && !clear_i && (cnt_q == 2'(BYTES_PER_WORD - 1));
  assign word_o       = word_q;
  assign word_valid_o = valid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= 2'd0;
      word_q  <= 32'd0;
      valid_q <= 1'b0;
    end else if (clear_i) begin
      cnt_q   <= 2'd0;
      word_q  <= 32'd0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= complete_o;
      if (byte_valid_i) begin
        word_q <= word_next_o;
        cnt_q  <= cnt_q + 2'd1;
      end
    end
  end

endmodule

// File: rtl/instruction_loader.sv
// Framed byte-stream program loader driving the instruction memory rw port.
// Optional read-back verification is enabled with `define LOADER_VERIFY_EN.
module instruction_loader
  import loader_pkg::*;
#(
  parameter int DEPTH = 4096,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [7:0]               rx_data,
  input  logic                     rx_valid,
  output logic                     rx_ready,
  output logic                     we,
  output logic [$clog2(DEPTH)-1:0] addr_rw,
  output logic [31:0]              write_instruction_rw,
  input  logic [31:0]              read_instruction_rw,
  output logic                     cpu_hold,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  output logic [CNT_W-1:0]         words_loaded
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [31:0] MAX_WORDS = 32'(DEPTH / 4);

  loader_state_t state_q, state_d;
  logic [CNT_W-1:0] words_q, words_d;
  logic [CNT_W-1:0] n_q, n_d;
  logic [31:0]      sum_q, sum_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  logic             hold_q, hold_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic             clear;

  logic             fire;
  logic [31:0]      pk_word;
  logic [31:0]      pk_word_next;
  logic             pk_complete;
  logic             pk_word_valid;
  logic [CNT_W-1:0] n_hdr;

`ifdef LOADER_VERIFY_EN
  logic [CNT_W-1:0] rd_idx_q, rd_idx_d;
  logic             issue_q, issue_d;
  logic             data_v_q, data_v_d;
  logic [31:0]      vsum_q, vsum_d;
  logic [31:0]      chk_q, chk_d;
  logic [31:0]      final_sum;
`else
  logic unused_rd;
  assign unused_rd = ^read_instruction_rw;
`endif

  assign rx_ready = (state_q == HDR) || (state_q == DATA) || (state_q == CHK);
  assign fire     = rx_valid && rx_ready;
  assign n_hdr    = pk_word_next[CNT_W-1:0];

  byte_packer u_packer (
    .clk          (clk),
    .rst          (rst),
    .clear_i      (clear),
    .byte_valid_i (fire),
    .byte_i       (rx_data),
    .word_o       (pk_word),
    .word_next_o  (pk_word_next),
    .complete_o   (pk_complete),
    .word_valid_o (pk_word_valid)
  );

  assign we                   = (state_q == WRITE) && pk_word_valid;
  assign addr_rw              = addr_q;
  assign write_instruction_rw = pk_word;
  assign busy                 = !(state_q inside {IDLE, DONE, ERROR});
  assign done                 = done_q;
  assign error                = error_q;
  assign cpu_hold             = hold_q;
  assign words_loaded         = words_q;

  always_comb begin
    state_d = state_q;
    words_d = words_q;
    n_d     = n_q;
    sum_d   = sum_q;
    done_d  = done_q;
    error_d = error_q;
    hold_d  = hold_q;
    addr_d  = addr_q;
    clear   = 1'b0;
`ifdef LOADER_VERIFY_EN
    rd_idx_d  = rd_idx_q;
    issue_d   = issue_q;
    data_v_d  = data_v_q;
    vsum_d    = vsum_q;
    chk_d     = chk_q;
    final_sum = 32'd0;
`endif
    case (state_q)
      IDLE, DONE, ERROR: begin
        if (start) begin
          state_d = HDR;
          done_d  = 1'b0;
          error_d = 1'b0;
          words_d = '0;
          sum_d   = 32'd0;
          hold_d  = 1'b1;
          clear   = 1'b1;
        end
      end
      HDR: begin
        if (pk_complete) begin
          n_d = n_hdr;
          if (32'(n_hdr) > MAX_WORDS) begin
            state_d = ERROR;
            error_d = 1'b1;
          end else if (n_hdr == '0) begin
            state_d = CHK;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (pk_complete) begin
          state_d = WRITE;
          addr_d  = AW'(word_addr(32'(words_q)));
        end
      end
      WRITE: begin
        sum_d   = sum_q + pk_word;
        words_d = words_q + CNT_W'(1);
        state_d = (words_d == n_q) ? CHK : DATA;
      end
      CHK: begin
        if (pk_complete) begin
`ifdef LOADER_VERIFY_EN
          // Prime the read pipeline: address 0 goes out on the first VERIFY cycle.
          state_d  = VERIFY;
          chk_d    = pk_word_next;
          vsum_d   = 32'd0;
          data_v_d = 1'b0;
          if (n_q != '0) begin
            addr_d   = '0;
            rd_idx_d = CNT_W'(1);
            issue_d  = 1'b1;
          end else begin
            rd_idx_d = '0;
            issue_d  = 1'b0;
          end
`else
          if (pk_word_next == sum_q) begin
            state_d = DONE;
            done_d  = 1'b1;
            hold_d  = 1'b0;
          end else begin
            state_d = ERROR;
            error_d = 1'b1;
          end
`endif
        end
      end
`ifdef LOADER_VERIFY_EN
      VERIFY: begin
        // Data returning now belongs to the address presented last cycle.
        final_sum = vsum_q + (data_v_q ? read_instruction_rw : 32'd0);
        vsum_d    = final_sum;
        data_v_d  = issue_q;
        if (rd_idx_q < n_q) begin
          addr_d   = AW'(word_addr(32'(rd_idx_q)));
          rd_idx_d = rd_idx_q + CNT_W'(1);
          issue_d  = 1'b1;
        end else begin
          issue_d = 1'b0;
        end
        if (!issue_q) begin
          if (final_sum == chk_q) begin
            state_d = DONE;
            done_d  = 1'b1;
            hold_d  = 1'b0;
          end else begin
            state_d = ERROR;
            error_d = 1'b1;
          end
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      words_q <= '0;
      n_q     <= '0;
      sum_q   <= 32'd0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      hold_q  <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      words_q <= words_d;
      n_q     <= n_d;
      sum_q   <= sum_d;
      done_q  <= done_d;
      error_q <= error_d;
      hold_q  <= hold_d;
      addr_q  <= addr_d;
    end
  end

`ifdef LOADER_VERIFY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_idx_q <= '0;
      issue_q  <= 1'b0;
      data_v_q <= 1'b0;
      vsum_q   <= 32'd0;
      chk_q    <= 32'd0;
    end else begin
      rd_idx_q <= rd_idx_d;
      issue_q  <= issue_d;
      data_v_q <= data_v_d;
      vsum_q   <= vsum_d;
      chk_q    <= chk_d;
    end
  end
`endif

endmodule

// File: tb/tb_instruction_loader.sv
// Self-checking bench for instruction_loader: table of frames plus hand-written
// corner sequences, with a write scoreboard and a small instruction memory model.
module tb_instruction_loader;

  localparam int DEPTH = 4096;
  localparam int CNT_W = 16;
  localparam int AW    = $clog2(DEPTH);

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic             rx_ready;
  logic             we;
  logic [AW-1:0]    addr_rw;
  logic [31:0]      write_instruction_rw;
  logic [31:0]      read_instruction_rw;
  logic             cpu_hold;
  logic             busy;
  logic             done;
  logic             error;
  logic [CNT_W-1:0] words_loaded;

  instruction_loader #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .start                (start),
    .rx_data              (rx_data),
    .rx_valid             (rx_valid),
    .rx_ready             (rx_ready),
    .we                   (we),
    .addr_rw              (addr_rw),
    .write_instruction_rw (write_instruction_rw),
    .read_instruction_rw  (read_instruction_rw),
    .cpu_hold             (cpu_hold),
    .busy                 (busy),
    .done                 (done),
    .error                (error),
    .words_loaded         (words_loaded)
  );

  always #5 clk = ~clk;

  // Memory model; in verify builds the write to 0x4 is deliberately corrupted.
  logic [31:0] mem [DEPTH/4];
  always @(posedge clk) begin
    if (we) begin
`ifdef LOADER_VERIFY_EN
      mem[addr_rw[AW-1:2]] <= (addr_rw == AW'(4)) ? 32'hDEADBEEE : write_instruction_rw;
`else
      mem[addr_rw[AW-1:2]] <= write_instruction_rw;
`endif
    end
    read_instruction_rw <= mem[addr_rw[AW-1:2]];
  end

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic [31:0]       n;
    logic [2:0][31:0]  w;
    logic [31:0]       chk;
    logic              exp_done;
    logic              vexp_done;
    logic [CNT_W-1:0]  exp_words;
  } frame_t;

  wr_t         sb[$];
  wr_t         exp_w;
  logic [31:0] rd_addrs[$];
  int          total = 0;
  int          bad   = 0;
  frame_t      tbl[7];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && we) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_we: got addr %h data %h want no write", addr_rw, write_instruction_rw);
      end else begin
        exp_w = sb.pop_front();
        check("wr_addr", 32'(addr_rw), exp_w.addr);
        check("wr_data", write_instruction_rw, exp_w.data);
        $display("write addr=%h data=%h", addr_rw, write_instruction_rw);
      end
    end
    if (!rst && busy && !we && !rx_ready) rd_addrs.push_back(32'(addr_rw));
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit slow, input bit chaos);
    bit ok;
    if (slow) begin
      rx_valid = 1'b0;
      start    = chaos;
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    rx_data  = b;
    rx_valid = 1'b1;
    ok       = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (rx_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check("byte_accept_timeout", 32'(ok), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input frame_t f, input bit slow, input int data_limit);
    int n_eff;
    n_eff = int'(f.n[CNT_W-1:0]);
    rd_addrs.delete();
    pulse_start();
    for (int i = 0; i < 4; i++) send_byte(8'(f.n >> (8 * i)), slow, i > 0);
    if (n_eff > DEPTH / 4) return;
    for (int k = 0; k < n_eff; k++) begin
      for (int i = 0; i < 4; i++) begin
        if (data_limit >= 0 && k * 4 + i >= data_limit) return;
        if (i == 3) sb.push_back('{addr: 32'(k * 4), data: f.w[k]});
        send_byte(8'(f.w[k] >> (8 * i)), slow, 1'b1);
      end
    end
    for (int i = 0; i < 4; i++) send_byte(8'(f.chk >> (8 * i)), slow, 1'b1);
  endtask

  task automatic check_result(input string tag, input logic exp_done, input logic [CNT_W-1:0] exp_words);
    bit idle;
    rx_valid = 1'b0;
    idle     = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy) begin
        idle = 1'b1;
        break;
      end
    end
    check({tag, "_finish_timeout"}, 32'(idle), 32'd1);
    check({tag, "_done"}, 32'(done), 32'(exp_done));
    check({tag, "_error"}, 32'(error), 32'(!exp_done));
    check({tag, "_cpu_hold"}, 32'(cpu_hold), 32'(!exp_done));
    check({tag, "_words"}, 32'(words_loaded), 32'(exp_words));
    check({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
    check({tag, "_pending_writes"}, 32'(sb.size()), 32'd0);
    $display("frame %s done=%0b error=%0b words=%0d", tag, done, error, words_loaded);
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
    check({tag, "_we"}, 32'(we), 32'd0);
    check({tag, "_addr"}, 32'(addr_rw), 32'd0);
    check({tag, "_wdata"}, write_instruction_rw, 32'd0);
    check({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_error"}, 32'(error), 32'd0);
    check({tag, "_words"}, 32'(words_loaded), 32'd0);
  endtask

  initial begin
    frame_t f;
    //            n             w2            w1            w0            chk           done  vdone words
    tbl[0] = '{32'd2,        {32'h0, 32'hDEADBEEF, 32'h00000013}, 32'hDEADBF02, 1'b1, 1'b0, 16'd2};
    tbl[1] = '{32'd2,        {32'h0, 32'hDEADBEEF, 32'h00000013}, 32'h00000000, 1'b0, 1'b0, 16'd2};
    tbl[2] = '{32'd0,        {32'h0, 32'h0, 32'h0},               32'h00000000, 1'b1, 1'b1, 16'd0};
    tbl[3] = '{32'd0,        {32'h0, 32'h0, 32'h0},               32'h00000001, 1'b0, 1'b0, 16'd0};
    tbl[4] = '{32'd3,        {32'd3, 32'd2, 32'd1},               32'd6,        1'b1, 1'b0, 16'd3};
    tbl[5] = '{32'hABCD0001, {32'h0, 32'h0, 32'h12345678},        32'h12345678, 1'b1, 1'b1, 16'd1};
    tbl[6] = '{32'd2,        {32'h0, 32'h00000002, 32'hFFFFFFFF}, 32'h00000001, 1'b1, 1'b0, 16'd2};

    rst      = 1'b1;
    start    = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 7; i++) begin
      send_frame(tbl[i], 1'b0, -1);
`ifdef LOADER_VERIFY_EN
      check_result($sformatf("tbl%0d", i), tbl[i].vexp_done, tbl[i].exp_words);
      if (i == 0) begin
        check("readback_count", 32'(rd_addrs.size() >= 2), 32'd1);
        if (rd_addrs.size() >= 2) begin
          check("readback_addr0", rd_addrs[0], 32'h0);
          check("readback_addr1", rd_addrs[1], 32'h4);
        end
      end
`else
      check_result($sformatf("tbl%0d", i), tbl[i].exp_done, tbl[i].exp_words);
      if (i == 0) check("no_readback", 32'(rd_addrs.size()), 32'd0);
`endif
    end

    // Oversized header: error right after the header, port stays closed.
    f = '{32'h00000401, {32'h0, 32'h0, 32'h0}, 32'h0, 1'b0, 1'b0, 16'd0};
    send_frame(f, 1'b0, -1);
    @(negedge clk);
    check("oversize_error_now", 32'(error), 32'd1);
    rx_valid = 1'b1;
    rx_data  = 8'hAA;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("oversize_rx_ready", 32'(rx_ready), 32'd0);
    end
    check_result("oversize", 1'b0, 16'd0);

    // Gapped rx_valid with stray start pulses must give identical writes.
    send_frame(tbl[0], 1'b1, -1);
`ifdef LOADER_VERIFY_EN
    check_result("slow", 1'b0, 16'd2);
`else
    check_result("slow", 1'b1, 16'd2);
`endif

    // Asynchronous reset after the sixth data byte.
    send_frame(tbl[0], 1'b0, 6);
    rx_valid = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    check_all_zero("midreset");
    check("midreset_pending_writes", 32'(sb.size()), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    send_frame(tbl[2], 1'b0, -1);
    check_result("after_reset", 1'b1, 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instruction_loader.md
Name: instruction_loader

Overview:
- Byte-stream program loader: the writer side of the instruction memory's read/write port.
- Accepts a framed image from an upstream byte source (UART receiver) over a valid/ready handshake.
- Assembles little-endian 32-bit words and writes them sequentially from byte address 0.
- Holds the CPU in reset while loading, then checks an additive checksum and reports done or error.

Parameters:
- DEPTH, 4096, instruction memory depth; must match the memory. addr_rw width is AW = $clog2(DEPTH). Maximum image is DEPTH/4 words.
- CNT_W, 16, width of the word counter and the header word-count field used.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  single-cycle pulse that begins a load
- rx_data  in  8  incoming byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  loader accepts byte this cycle
- we  out  1  instruction memory write enable
- addr_rw  out  AW  byte address to instruction memory, word-aligned
- write_instruction_rw  out  32  write data to instruction memory
- read_instruction_rw  in  32  registered read data from memory, valid the cycle after the address is presented with we=0
- cpu_hold  out  1  high while loading; drives the core's reset
- busy  out  1  state is neither IDLE, DONE nor ERROR
- done  out  1  level; last load succeeded
- error  out  1  level; last load failed
- words_loaded  out  CNT_W  number of words written so far

Behaviour:
- Reset value of every output is 0: rx_ready, we, addr_rw, write_instruction_rw, cpu_hold, busy, done, error, words_loaded. State resets to IDLE.
- rst mid-load aborts immediately. Memory keeps any partially written words.
- Frame format, all fields little-endian:
  - 4-byte word count N; only the low CNT_W bits are used, upper bits are ignored.
  - N x 4 data bytes.
  - 4-byte checksum, equal to the sum mod 2^32 of all N words.
- A byte transfers on a cycle where rx_valid && rx_ready. rx_ready is registered-free: high exactly in states HDR, DATA and CHK.
- State IDLE/DONE/ERROR: on start -> HDR. Entering HDR clears done, error, words_loaded and the running sum, and sets cpu_hold=1.
- start in any other state is ignored.
- HDR: collect 4 bytes.
  - If N > DEPTH/4 -> ERROR.
  - If N == 0 -> CHK.
  - Otherwise -> DATA.
- DATA: collect 4 bytes into a word. The cycle after the 4th byte -> WRITE.
- WRITE: one cycle with rx_ready=0.
  - Outputs: we=1, addr_rw = words_loaded<<2, write_instruction_rw = assembled word.
  - Add the word to the sum and increment words_loaded.
  - If the new count == N -> CHK, else -> DATA.
- CHK: collect 4 bytes, then compare.
  - Feature off: compare against the running sum; equal -> DONE, else -> ERROR.
  - Feature on: -> VERIFY.
- DONE: done=1, cpu_hold=0. ERROR: error=1, cpu_hold stays 1 until the next successful load.
- we is never asserted outside WRITE. addr_rw holds its last value when idle.
- Byte lane order: the first byte received goes to bits [7:0].
- Back-to-back rx_valid is supported. Throughput is 5 cycles per word minimum.

Optional Feature:
- Macro: LOADER_VERIFY_EN.
- Defined: after CHK, state VERIFY reads back words 0..N-1 through the rw port with we=0.
  - The address is issued on cycle k; read_instruction_rw is summed on cycle k+1. The loop is pipelined at 1 word/cycle plus one drain cycle.
  - The read-back sum is compared with the received checksum; equal -> DONE, else -> ERROR.
  - With N == 0 the sum is 0.
- Undefined: no VERIFY state. The comparison uses the running sum of received words, and the rw port is never read.

Decomposition:
- Shared package loader_pkg holds:
  - state enum loader_state_t (IDLE, HDR, DATA, WRITE, CHK, VERIFY, DONE, ERROR);
  - constant BYTES_PER_WORD = 4;
  - function word_addr(idx) returning idx<<2.
- One sub-module: byte_packer. It shifts 4 accepted bytes into a little-endian 32-bit word, with a one-cycle word_valid pulse and a clear input. It is reused for header, data and checksum.

Test Plan:
- Header N=2, words 0x00000013 and 0xDEADBEEF, checksum 0xDEADBF02. Expected:
  - we pulses at addr 0x0 and 0x4 with those data;
  - then done=1, cpu_hold=0, words_loaded=2.
- Same frame with checksum 0x00000000 -> error=1, done=0, cpu_hold=1 after the last byte.
- N=0, checksum 0 -> no we pulses, done=1. N=0 with checksum 1 -> error=1.
- N=DEPTH/4+1 (0x401 for DEPTH=4096) -> error=1 after the 4th header byte; rx_ready=0 afterwards; no writes.
- rx_valid toggling every other cycle, plus start pulses during HDR/DATA -> identical writes as the first scenario, start ignored. rst asserted after the 6th data byte -> all outputs 0 next edge.
- LOADER_VERIFY_EN with a memory model whose write at addr 0x4 is corrupted to 0xDEADBEEE -> readback addresses 0x0, 0x4 presented on consecutive cycles -> error=1.
